// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache controller.
// Sits between the PC register and a multi-cycle backing instruction memory.
// A hit returns the instruction combinationally. A miss stalls the fetch and
// refills the whole line, word 0 first, using a req/ready handshake.
//
// Ports:
//   clk        core clock, rising edge
//   RST        synchronous active-high reset
//   pc         fetch address (bits [1:0] ignored)
//   instr      fetched instruction (NOP_INSTR while stalled)
//   stall_if   1 = fetch not served this cycle, PC must hold
//   mem_req    backing-memory word read request
//   mem_addr   word-aligned backing-memory address (0 when idle)
//   mem_ready  backing memory returns mem_rdata this cycle
//   mem_rdata  backing-memory read data
//   hit_cnt    (ICACHE_PERF_EN only) IDLE cycles that hit
//   miss_cnt   (ICACHE_PERF_EN only) refills started
//
// Optional feature macro: ICACHE_PERF_EN adds the hit/miss counters.
//
// state  | meaning
// IDLE   | lookup pc; a hit is served, a miss starts a refill
// REFILL | fetch line words 0..WORDS_PER_LINE-1 for the latched miss address
module icache_ctrl #(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall_if,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WB  = $clog2(WORDS_PER_LINE);
    localparam int IB  = $clog2(LINES);
    localparam int OFF = WB + 2;
    localparam int TW  = 32 - OFF - IB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t          state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]   tag_mem  [LINES];
    logic [31:0]     data_mem [LINES][WORDS_PER_LINE];
    logic [IB-1:0]   miss_index;
    logic [TW-1:0]   miss_tag;
    logic [WB-1:0]   k;

    logic [WB-1:0]   pc_word;
    logic [IB-1:0]   pc_index;
    logic [TW-1:0]   pc_tag;
    logic            pc_unused;
    logic            lookup_hit;
    logic            serve;
    logic            fill_beat;
    logic            last_beat;

    assign pc_word   = pc[OFF-1:2];
    assign pc_index  = pc[OFF+IB-1:OFF];
    assign pc_tag    = pc[31:OFF+IB];
    assign pc_unused = ^pc[1:0];

    assign lookup_hit = valid[pc_index] && (tag_mem[pc_index] == pc_tag);

    // RST gates everything so the reset cycle already looks like a cold cache
    // and a mem_ready arriving during it is dropped.
    assign serve     = !RST && (state == IDLE) && lookup_hit;
    assign fill_beat = !RST && (state == REFILL) && mem_ready;
    assign last_beat = fill_beat && (k == WB'(WORDS_PER_LINE - 1));

    assign instr    = serve ? data_mem[pc_index][pc_word] : NOP_INSTR;
    assign stall_if = !serve;
    assign mem_req  = !RST && (state == REFILL);
    assign mem_addr = mem_req ? {miss_tag, miss_index, k, 2'b00} : 32'h0;

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            k          <= '0;
            miss_index <= '0;
            miss_tag   <= '0;
`ifdef ICACHE_PERF_EN
            hit_cnt    <= '0;
            miss_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_hit) begin
`ifdef ICACHE_PERF_EN
                        hit_cnt <= hit_cnt + 32'd1;
`endif
                    end else begin
                        miss_index      <= pc_index;
                        miss_tag        <= pc_tag;
                        k               <= '0;
                        valid[pc_index] <= 1'b0;
                        state           <= REFILL;
`ifdef ICACHE_PERF_EN
                        miss_cnt        <= miss_cnt + 32'd1;
`endif
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        k <= k + 1'b1;
                        if (k == WB'(WORDS_PER_LINE - 1)) begin
                            valid[miss_index] <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[miss_index][k] <= mem_rdata;
        end
        if (last_beat) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios followed by randomized fetches,
// every cycle compared against a line-level reference model of the cache.
module tb_icache_ctrl;

    localparam int          LINES      = 16;
    localparam int          LINE_BYTES = 16;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] KEY        = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_ctrl dut (
        .clk       (clk),
        .RST       (rst),
        .pc        (pc),
        .instr     (instr),
        .stall_if  (stall_if),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: which line number each index holds, plus the queue of
    // word addresses still owed by an in-flight refill
    bit          m_valid [LINES];
    int unsigned m_line  [LINES];
    logic [31:0] q[$];
    int unsigned fill_line;
    int          wait_cnt  = 0;
    int unsigned m_hits    = 0;
    int unsigned m_misses  = 0;
    bit          prev_rst  = 1'b0;
    bit          last_stall = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst_v, input logic [31:0] pc_v, input int w, input bit stray);
        bit          ready_now;
        bit          exp_hit;
        int unsigned line;
        int unsigned idx;
        @(negedge clk);
        rst  = rst_v;
        pc   = pc_v;
        line = pc_v / LINE_BYTES;
        idx  = line % LINES;
        ready_now = !rst_v && (q.size() > 0) && (wait_cnt >= w);
        if (rst_v || (stray && q.size() == 0))
            mem_ready = 1'($urandom_range(1, 0));
        else
            mem_ready = ready_now;
        #1;
        mem_rdata = mem_word(mem_addr);
        #1;
        exp_hit = !rst_v && (q.size() == 0) && m_valid[idx] && (m_line[idx] == line);
        chk("stall_if", 32'(stall_if), 32'(!exp_hit));
        chk("instr", instr, exp_hit ? mem_word(pc_v & ~32'h3) : NOP);
        chk("mem_req", 32'(mem_req), 32'(!rst_v && (q.size() > 0)));
        if (!rst_v && q.size() > 0)
            chk("mem_addr", mem_addr, q[0]);
        else if (rst_v || prev_rst)
            chk("mem_addr_rst", mem_addr, 32'h0);
`ifdef ICACHE_PERF_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
        last_stall = stall_if;
        prev_rst   = rst_v;

        if (rst_v) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            q.delete();
            wait_cnt = 0;
            m_hits   = 0;
            m_misses = 0;
        end else if (q.size() > 0) begin
            if (ready_now) begin
                void'(q.pop_front());
                wait_cnt = 0;
                if (q.size() == 0) begin
                    m_valid[fill_line % LINES] = 1'b1;
                    m_line[fill_line % LINES]  = fill_line;
                end
            end else begin
                wait_cnt++;
            end
        end else if (exp_hit) begin
            m_hits++;
        end else begin
            fill_line    = line;
            m_valid[idx] = 1'b0;
            for (int i = 0; i < LINE_BYTES / 4; i++)
                q.push_back(line * LINE_BYTES + 4 * i);
            wait_cnt = 0;
            m_misses++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int w, output int stalls);
        bit served = 1'b0;
        stalls = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, a, w, 1'b0);
            if (!last_stall) begin
                served = 1'b1;
                break;
            end
            stalls++;
        end
        chk("fetch_served", 32'(served), 32'd1);
    endtask

    initial begin
        int stalls;
        logic [31:0] rpc;
        rst       = 1'b1;
        pc        = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // cold miss then hits on the same line
        step(1'b1, 32'h0, 0, 1'b0);
        fetch(32'h0, 0, stalls);
        chk("cold_penalty", stalls, 32'd5);
        step(1'b0, 32'h4, 0, 1'b0);
        chk("hit_4", instr, 32'hA5A5_0004);
        step(1'b0, 32'h8, 0, 1'b0);
        chk("hit_8", instr, 32'hA5A5_0008);
        step(1'b0, 32'hC, 0, 1'b0);
        chk("hit_c", instr, 32'hA5A5_000C);

        // conflict eviction on index 0
        fetch(32'h100, 0, stalls);
        chk("conflict_fill", stalls, 32'd5);
        fetch(32'h000, 0, stalls);
        chk("conflict_refetch", stalls, 32'd5);

        // three wait states per word
        step(1'b1, 32'h0, 0, 1'b0);
        fetch(32'h200, 3, stalls);
        chk("wait_penalty", stalls, 32'd17);

        // reset after two words of a refill to 0x40
        step(1'b1, 32'h0, 0, 1'b0);
        step(1'b0, 32'h40, 0, 1'b0);
        step(1'b0, 32'h40, 0, 1'b0);
        step(1'b0, 32'h40, 0, 1'b0);
        step(1'b1, 32'h40, 0, 1'b0);
        fetch(32'h40, 0, stalls);
        chk("post_reset_refill", stalls, 32'd5);

        // randomized fetch stream with stray readies, wait states, resets
        rpc = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            if (!last_stall || $urandom_range(3, 0) == 0)
                rpc = (32'($urandom_range(2, 0)) << 8) | (32'($urandom_range(3, 0)) << 4) |
                      (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
            step(($urandom_range(99, 0) == 0), rpc, $urandom_range(2, 0), 1'b1);
        end

`ifdef ICACHE_PERF_EN
        step(1'b1, 32'h0, 0, 1'b0);
        fetch(32'h0, 0, stalls);
        step(1'b0, 32'h4, 0, 1'b0);
        step(1'b0, 32'h8, 0, 1'b0);
        step(1'b0, 32'hC, 0, 1'b0);
        @(negedge clk);
        #1;
        chk("perf_miss", miss_cnt, 32'd1);
        chk("perf_hit", hit_cnt, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
